// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control decoder.
// ILLEGAL_TRAP_EN adds an illegal-opcode flag to the decoded control word.
package ctrl_pkg;

  // Opcodes (instruction bits [INSTR_W-1 -: 4])
  localparam logic [3:0] OP_ADI = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  // ALU second operand source
  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_IMM6 = 2'b01;
  localparam logic [1:0] SRC2_IMM9 = 2'b10;
  localparam logic [1:0] SRC2_OFS  = 2'b11;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  // Write-back data select
  localparam logic [1:0] D3_ALU = 2'b00;
  localparam logic [1:0] D3_MEM = 2'b01;
  localparam logic [1:0] D3_LHI = 2'b10;
  localparam logic [1:0] D3_PC1 = 2'b11;

  // Branch kind
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_JAL  = 2'b10;
  localparam logic [1:0] BR_JLR  = 2'b11;

  // Which instruction field feeds a register address
  typedef enum logic [1:0] {SEL_RA, SEL_RB, SEL_RC} reg_sel_e;

  // LM/SM sequencer state
  typedef enum logic {S_IDLE, S_MULTI} seq_state_e;

  // Per-opcode control word; a2 is always RB unless the sequencer overrides it
  typedef struct packed {
    reg_sel_e   a1_sel;
    reg_sel_e   a3_sel;
    logic       rr_wr_en;
    logic       mem_wr_en;
    logic [1:0] alu_src2;
    logic [1:0] alu_oper;
    logic [1:0] d3_sel;
    logic [1:0] branch_type;
    logic       multi;
    logic       is_lm;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

endpackage

// File: rtl/ctrl_field_decode.sv
// Combinational opcode -> control-field table.
// With ILLEGAL_TRAP_EN, undefined opcodes are flagged and stripped of side effects;
// otherwise they fall through to the ADD decode.
module ctrl_field_decode import ctrl_pkg::*; (
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  // Start from the ADD-like default and patch per opcode
  always_comb begin
    ctrl             = '0;
    ctrl.a1_sel      = SEL_RA;
    ctrl.a3_sel      = SEL_RC;
    ctrl.rr_wr_en    = 1'b1;
    ctrl.alu_src2    = SRC2_REG;
    ctrl.alu_oper    = ALU_ADD;
    ctrl.d3_sel      = D3_ALU;
    ctrl.branch_type = BR_NONE;
    case (opcode)
      OP_ADD: ;
      OP_ADI: begin
        ctrl.a3_sel   = SEL_RB;
        ctrl.alu_src2 = SRC2_IMM6;
      end
      OP_NDU: ctrl.alu_oper = ALU_NAND;
      OP_LHI: begin
        ctrl.a3_sel   = SEL_RA;
        ctrl.d3_sel   = D3_LHI;
        ctrl.alu_oper = ALU_PASS;
      end
      OP_LW: begin
        ctrl.a1_sel   = SEL_RB;
        ctrl.a3_sel   = SEL_RA;
        ctrl.alu_src2 = SRC2_IMM6;
        ctrl.d3_sel   = D3_MEM;
      end
      OP_SW: begin
        ctrl.rr_wr_en  = 1'b0;
        ctrl.mem_wr_en = 1'b1;
      end
      OP_BEQ: begin
        ctrl.rr_wr_en    = 1'b0;
        ctrl.branch_type = BR_BEQ;
      end
      OP_JAL: begin
        ctrl.a3_sel      = SEL_RA;
        ctrl.d3_sel      = D3_PC1;
        ctrl.branch_type = BR_JAL;
      end
      OP_JLR: begin
        ctrl.a1_sel      = SEL_RB;
        ctrl.a3_sel      = SEL_RA;
        ctrl.d3_sel      = D3_PC1;
        ctrl.branch_type = BR_JLR;
      end
      OP_LM: begin
        ctrl.multi    = 1'b1;
        ctrl.is_lm    = 1'b1;
        ctrl.alu_src2 = SRC2_OFS;
        ctrl.d3_sel   = D3_MEM;
      end
      OP_SM: begin
        ctrl.multi     = 1'b1;
        ctrl.alu_src2  = SRC2_OFS;
        ctrl.rr_wr_en  = 1'b0;
        ctrl.mem_wr_en = 1'b1;
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        ctrl.illegal  = 1'b1;
        ctrl.rr_wr_en = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/multi_op_control_decoder.sv
// Registered ID-stage control decoder with an LM/SM micro-op sequencer.
// Optional: ILLEGAL_TRAP_EN adds the illegal_op output for undefined opcodes.
module multi_op_control_decoder import ctrl_pkg::*; #(
  parameter int NUM_REGS   = 8,
  parameter int REG_ADDR_W = 3,   // must equal $clog2(NUM_REGS)
  parameter int INSTR_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [INSTR_W-1:0]    in_instr,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  fetch_stall,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] rr_a1,
  output logic [REG_ADDR_W-1:0] rr_a2,
  output logic [REG_ADDR_W-1:0] rr_a3,
  output logic                  rr_wr_en,
  output logic                  mem_wr_en,
  output logic [1:0]            exe_alu_src2,
  output logic [1:0]            exe_alu_oper,
  output logic [1:0]            reg_d3_sel,
  output logic [1:0]            branch_type,
  output logic [REG_ADDR_W-1:0] uop_offset,
  output logic                  last_uop
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_op
`endif
);

  // Everything presented to the RR pipeline register
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] a1;
    logic [REG_ADDR_W-1:0] a2;
    logic [REG_ADDR_W-1:0] a3;
    logic                  wr;
    logic                  mem;
    logic [1:0]            src2;
    logic [1:0]            oper;
    logic [1:0]            d3;
    logic [1:0]            br;
    logic [REG_ADDR_W-1:0] ofs;
    logic                  last;
    logic                  fs;
`ifdef ILLEGAL_TRAP_EN
    logic                  ill;
`endif
  } uop_out_t;

  seq_state_e            state_q, state_d;
  logic [NUM_REGS-1:0]   mask_q, mask_d;
  logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
  logic [INSTR_W-1:0]    instr_q, instr_d;
  uop_out_t              out_q, out_d;

  logic [INSTR_W-1:0]    cur_instr;
  logic [NUM_REGS-1:0]   avail_mask, rem_mask;
  logic [REG_ADDR_W-1:0] pick, cur_ofs, f_ra, f_rb, f_rc;
  ctrl_t                 dec;

  function automatic logic [REG_ADDR_W-1:0] reg_of(input reg_sel_e s,
      input logic [REG_ADDR_W-1:0] ra, input logic [REG_ADDR_W-1:0] rb,
      input logic [REG_ADDR_W-1:0] rc);
    case (s)
      SEL_RA:  return ra;
      SEL_RB:  return rb;
      default: return rc;
    endcase
  endfunction

  // During an expansion the latched LM/SM word stands in for the (held) IF/ID word
  always_comb begin
    cur_instr = (state_q == S_MULTI) ? instr_q : in_instr;
    f_ra      = cur_instr[9 +: REG_ADDR_W];
    f_rb      = cur_instr[6 +: REG_ADDR_W];
    f_rc      = cur_instr[3 +: REG_ADDR_W];
    cur_ofs   = (state_q == S_MULTI) ? cnt_q : '0;
  end

  ctrl_field_decode u_dec (
    .opcode (cur_instr[INSTR_W-1 -: 4]),
    .ctrl   (dec)
  );

  // Lowest-set-bit priority encoder over the mask still owed
  always_comb begin
    avail_mask = (state_q == S_MULTI) ? mask_q : cur_instr[NUM_REGS-1:0];
    pick = '0;
    for (int k = NUM_REGS - 1; k >= 0; k--)
      if (avail_mask[k]) pick = REG_ADDR_W'(k);
    rem_mask = avail_mask & ~(NUM_REGS'(1) << pick);
  end

  // Next-state and next-output: flush > stall > sequencer/accept > bubble
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    out_d   = '0;
    if (flush) begin
      state_d = S_IDLE;
      mask_d  = '0;
      cnt_d   = '0;
    end else if (stall_in) begin
      out_d = out_q;
    end else if (state_q == S_MULTI || in_valid) begin
      // An LM/SM with an empty mask is consumed silently
      if (!(dec.multi && avail_mask == '0)) begin
        out_d.valid = 1'b1;
        out_d.a1    = reg_of(dec.a1_sel, f_ra, f_rb, f_rc);
        out_d.a2    = f_rb;
        out_d.a3    = reg_of(dec.a3_sel, f_ra, f_rb, f_rc);
        out_d.wr    = dec.rr_wr_en;
        out_d.mem   = dec.mem_wr_en;
        out_d.src2  = dec.alu_src2;
        out_d.oper  = dec.alu_oper;
        out_d.d3    = dec.d3_sel;
        out_d.br    = dec.branch_type;
        out_d.last  = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        out_d.ill   = dec.illegal;
        if (dec.illegal) begin
          out_d.mem = 1'b0;
          out_d.br  = BR_NONE;
        end
`endif
        if (dec.multi) begin
          out_d.ofs = cur_ofs;
          if (dec.is_lm) out_d.a3 = pick;
          else           out_d.a2 = pick;
          if (rem_mask != '0) begin
            state_d    = S_MULTI;
            mask_d     = rem_mask;
            cnt_d      = cur_ofs + REG_ADDR_W'(1);
            instr_d    = cur_instr;
            out_d.last = 1'b0;
            out_d.fs   = 1'b1;
          end else begin
            state_d = S_IDLE;
            mask_d  = '0;
            cnt_d   = '0;
          end
        end
      end
    end
  end

  // State, sequencer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      out_q   <= out_d;
    end
  end

  assign fetch_stall  = out_q.fs;
  assign out_valid    = out_q.valid;
  assign rr_a1        = out_q.a1;
  assign rr_a2        = out_q.a2;
  assign rr_a3        = out_q.a3;
  assign rr_wr_en     = out_q.wr;
  assign mem_wr_en    = out_q.mem;
  assign exe_alu_src2 = out_q.src2;
  assign exe_alu_oper = out_q.oper;
  assign reg_d3_sel   = out_q.d3;
  assign branch_type  = out_q.br;
  assign uop_offset   = out_q.ofs;
  assign last_uop     = out_q.last;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_op   = out_q.ill;
`endif

endmodule

// File: tb/tb_multi_op_control_decoder.sv
// Bench: queue-based reference model of the decoder plus directed literal checks.
module tb_multi_op_control_decoder;

  localparam int NR = 8;
  localparam int AW = 3;
  localparam int IW = 16;

  logic          clk, reset, in_valid, stall_in, flush;
  logic [IW-1:0] in_instr;
  logic          fetch_stall, out_valid, rr_wr_en, mem_wr_en, last_uop;
  logic [AW-1:0] rr_a1, rr_a2, rr_a3, uop_offset;
  logic [1:0]    exe_alu_src2, exe_alu_oper, reg_d3_sel, branch_type;
`ifdef ILLEGAL_TRAP_EN
  logic          illegal_op;
`endif

  multi_op_control_decoder #(.NUM_REGS(NR), .REG_ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .stall_in(stall_in), .flush(flush), .fetch_stall(fetch_stall),
    .out_valid(out_valid), .rr_a1(rr_a1), .rr_a2(rr_a2), .rr_a3(rr_a3),
    .rr_wr_en(rr_wr_en), .mem_wr_en(mem_wr_en), .exe_alu_src2(exe_alu_src2),
    .exe_alu_oper(exe_alu_oper), .reg_d3_sel(reg_d3_sel),
    .branch_type(branch_type), .uop_offset(uop_offset), .last_uop(last_uop)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [2:0] a1, a2, a3; logic wr, mem;
    logic [1:0] src2, oper, d3, br; logic [2:0] ofs; logic last, ill;
  } uop_t;

  uop_t cur;          // what the outputs must show now
  uop_t pend[$];      // micro-ops still owed by an LM/SM
  uop_t newq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Expand one instruction into its list of micro-ops
  task automatic expand(input logic [15:0] ins);
    logic [3:0] op;
    logic [2:0] ra, rb, rc;
    uop_t u;
    int n, o;
    op = ins[15:12]; ra = ins[11:9]; rb = ins[8:6]; rc = ins[5:3];
    newq.delete();
    if (op == 4'd6 || op == 4'd7) begin
      n = $countones(ins[7:0]);
      o = 0;
      for (int k = 0; k < 8; k++) begin
        if (ins[k]) begin
          u = '0; u.v = 1; u.a1 = ra; u.a2 = rb; u.a3 = rc; u.src2 = 2'd3;
          u.ofs = 3'(o); u.last = (o == n - 1);
          if (op == 4'd6) begin u.a3 = 3'(k); u.d3 = 2'd1; u.wr = 1; end
          else begin u.a2 = 3'(k); u.mem = 1; end
          newq.push_back(u);
          o++;
        end
      end
    end else begin
      u = '0; u.v = 1; u.last = 1; u.a1 = ra; u.a2 = rb; u.a3 = rc;
      case (op)
        4'd0:  begin u.a3 = rb; u.wr = 1; u.src2 = 2'd1; end
        4'd1:  u.wr = 1;
        4'd2:  begin u.wr = 1; u.oper = 2'd1; end
        4'd3:  begin u.a3 = ra; u.wr = 1; u.d3 = 2'd2; u.oper = 2'd2; end
        4'd4:  begin u.a1 = rb; u.a3 = ra; u.wr = 1; u.src2 = 2'd1; u.d3 = 2'd1; end
        4'd5:  u.mem = 1;
        4'd8:  begin u.a3 = ra; u.wr = 1; u.d3 = 2'd3; u.br = 2'd2; end
        4'd9:  begin u.a1 = rb; u.a3 = ra; u.wr = 1; u.d3 = 2'd3; u.br = 2'd3; end
        4'd12: u.br = 2'd1;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          u.ill = 1;
`else
          u.wr = 1;
`endif
        end
      endcase
      newq.push_back(u);
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(cur.v));
    chk("fetch_stall", 32'(fetch_stall), 32'(pend.size() != 0));
    chk("rr_wr_en", 32'(rr_wr_en), 32'(cur.v & cur.wr));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(cur.v & cur.mem));
    if (cur.v) begin
      chk("rr_a1", 32'(rr_a1), 32'(cur.a1));
      chk("rr_a2", 32'(rr_a2), 32'(cur.a2));
      chk("rr_a3", 32'(rr_a3), 32'(cur.a3));
      chk("alu_src2", 32'(exe_alu_src2), 32'(cur.src2));
      chk("alu_oper", 32'(exe_alu_oper), 32'(cur.oper));
      chk("d3_sel", 32'(reg_d3_sel), 32'(cur.d3));
      chk("branch_type", 32'(branch_type), 32'(cur.br));
      chk("uop_offset", 32'(uop_offset), 32'(cur.ofs));
      chk("last_uop", 32'(last_uop), 32'(cur.last));
`ifdef ILLEGAL_TRAP_EN
      chk("illegal_op", 32'(illegal_op), 32'(cur.ill));
`endif
    end
  endtask

  // One clock: drive at negedge, advance the model, compare after the edge
  task automatic cycle(input logic v, input logic [15:0] ins, input logic st, input logic fl);
    @(negedge clk);
    in_valid = v; in_instr = ins; stall_in = st; flush = fl;
    if (fl) begin
      cur = '0; pend.delete();
    end else if (!st) begin
      if (pend.size() > 0) cur = pend.pop_front();
      else if (v) begin
        expand(ins);
        if (newq.size() == 0) cur = '0;
        else begin cur = newq.pop_front(); pend = newq; end
      end else cur = '0;
    end
    @(posedge clk); #1;
    compare();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    logic [15:0] w;
    int r;
    r  = $urandom_range(0, 9);
    op = (r < 4) ? ((r < 2) ? 4'd6 : 4'd7) : 4'($urandom_range(0, 15));
    w  = {op, 12'($urandom)};
    if (op == 4'd6 || op == 4'd7) begin
      case ($urandom_range(0, 4))
        0: w[7:0] = 8'h00;
        1: w[7:0] = 8'h01 << $urandom_range(0, 7);
        2: w[7:0] = 8'hFF;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = '0;
    reset = 1; in_valid = 0; in_instr = '0; stall_in = 0; flush = 0;
    #12;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset fetch_stall", 32'(fetch_stall), 0);
    chk("reset rr_a3", 32'(rr_a3), 0);
    @(negedge clk); reset = 0;

    // ADD R3 = R1 + R2
    cycle(1, 16'h1298, 0, 0);
    chk("add valid", 32'(out_valid), 1);
    chk("add a1", 32'(rr_a1), 1);
    chk("add a2", 32'(rr_a2), 2);
    chk("add a3", 32'(rr_a3), 3);
    chk("add wr", 32'(rr_wr_en), 1);
    chk("add last", 32'(last_uop), 1);
    chk("add fs", 32'(fetch_stall), 0);

    // LM RA=2 mask 0x15; the held next word must wait
    cycle(1, 16'h6415, 0, 0);
    chk("lm0 a3", 32'(rr_a3), 0); chk("lm0 ofs", 32'(uop_offset), 0);
    chk("lm0 fs", 32'(fetch_stall), 1); chk("lm0 a1", 32'(rr_a1), 2);
    cycle(1, 16'h1298, 0, 0);
    chk("lm1 a3", 32'(rr_a3), 2); chk("lm1 ofs", 32'(uop_offset), 1);
    chk("lm1 fs", 32'(fetch_stall), 1); chk("lm1 last", 32'(last_uop), 0);
    cycle(1, 16'h1298, 0, 0);
    chk("lm2 a3", 32'(rr_a3), 4); chk("lm2 ofs", 32'(uop_offset), 2);
    chk("lm2 fs", 32'(fetch_stall), 0); chk("lm2 last", 32'(last_uop), 1);
    cycle(0, 16'h0, 0, 0);

    // SM mask 0x80 with a two-cycle downstream stall
    cycle(1, 16'h7080, 0, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);
    chk("sm held valid", 32'(out_valid), 1);
    chk("sm a2", 32'(rr_a2), 7);
    chk("sm mem", 32'(mem_wr_en), 1);
    chk("sm fs", 32'(fetch_stall), 0);
    cycle(0, 16'h0, 0, 0);

    // LM mask 0xFF, flush after the third micro-op
    cycle(1, 16'h60FF, 0, 0);
    cycle(1, 16'h1298, 0, 0);
    cycle(1, 16'h1298, 0, 0);
    chk("lmff 3rd a3", 32'(rr_a3), 2);
    chk("lmff 3rd fs", 32'(fetch_stall), 1);
    cycle(1, 16'h1298, 0, 1);
    chk("flush valid", 32'(out_valid), 0);
    chk("flush fs", 32'(fetch_stall), 0);
    cycle(0, 16'h0, 0, 0);

    // Reset pulsed during an expansion takes effect without a clock
    cycle(1, 16'h60FF, 0, 0);
    cycle(1, 16'h1298, 0, 0);
    #2;
    in_valid = 0; stall_in = 0; flush = 0;
    reset = 1;
    #1;
    chk("async rst valid", 32'(out_valid), 0);
    chk("async rst fs", 32'(fetch_stall), 0);
    chk("async rst a3", 32'(rr_a3), 0);
    chk("async rst wr", 32'(rr_wr_en), 0);
    cur = '0; pend.delete();
    @(negedge clk); reset = 0;

    // Empty mask: consumed with no micro-op
    cycle(1, 16'h6400, 0, 0);
    chk("lm0mask valid", 32'(out_valid), 0);
    chk("lm0mask wr", 32'(rr_wr_en), 0);
    cycle(1, 16'h7000, 0, 0);
    chk("sm0mask mem", 32'(mem_wr_en), 0);

    // Undefined opcode 1111
    cycle(1, 16'hF298, 0, 0);
    chk("op15 valid", 32'(out_valid), 1);
`ifdef ILLEGAL_TRAP_EN
    chk("op15 illegal", 32'(illegal_op), 1);
    chk("op15 wr", 32'(rr_wr_en), 0);
`else
    chk("op15 as add a3", 32'(rr_a3), 3);
    chk("op15 as add wr", 32'(rr_wr_en), 1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++)
      cycle(($urandom_range(0, 9) < 8), rand_instr(),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 24) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_op_control_decoder.md
Name: multi_op_control_decoder

Overview:
Registered ID-stage control decoder for the 16-bit pipelined RISC, parametrised in register-file size. It covers the full ISA, including BEQ, JAL and JLR, plus LM/SM. LM/SM are expanded by an internal sequencer into one micro-op per set mask bit. Fetch is stalled while an expansion is in progress. Outputs feed the RR stage pipeline register.

Parameters:
NUM_REGS, 8, architectural register count; LM/SM mask width.
REG_ADDR_W, 3, register address width; must equal clog2(NUM_REGS).
INSTR_W, 16, instruction width; opcode is always bits [INSTR_W-1:INSTR_W-4].

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  ID holds a valid instruction
in_instr  in  INSTR_W  instruction word
stall_in  in  1  downstream stall; hold all outputs and state
flush  in  1  branch or jump flush; kill current and pending micro-ops
fetch_stall  out  1  high while the sequencer still owes micro-ops; IF/ID must hold
out_valid  out  1  micro-op valid
rr_a1, rr_a2, rr_a3  out  REG_ADDR_W each  resolved register addresses
rr_wr_en  out  1  register write enable
mem_wr_en  out  1  data memory write
exe_alu_src2  out  2  00 reg, 01 sext imm6, 10 imm9/LHI, 11 LM/SM offset
exe_alu_oper  out  2  00 add, 01 nand, 10 pass/none
reg_d3_sel  out  2  00 ALU, 01 mem, 10 LHI, 11 PC+1
branch_type  out  2  00 none, 01 BEQ, 10 JAL, 11 JLR
uop_offset  out  REG_ADDR_W  LM/SM word offset, counted from 0
last_uop  out  1  final micro-op of this instruction

Behaviour:
- Reset (async): all outputs 0; state IDLE; mask register 0; offset counter 0.
- Latency: one cycle from acceptance to registered outputs. Acceptance requires in_valid & ~fetch_stall & ~stall_in.
- stall_in high: every register holds, including outputs, mask and offset. stall_in has priority over acceptance but not over flush or reset.
- flush, synchronous: next cycle out_valid=0, state=IDLE, mask cleared, fetch_stall=0. flush wins over stall_in and over a same-cycle acceptance.
- Fields: RA=[11:9], RB=[8:6], RC=[5:3], cz=[1:0], mask=[NUM_REGS-1:0].
- Single-op opcodes produce one micro-op with last_uop=1.
  - ADD/ADC/ADZ 0001: a3=RC, rr_wr_en=1.
  - ADI 0000: src2=01, a3=RB.
  - NDU 0010: oper=01.
  - LHI 0011: a3=RA, d3=10, oper=10.
  - LW 0100: a3=RA, a1=RB, src2=01, d3=01.
  - SW 0101: mem_wr_en=1, no register write.
  - BEQ 1100: a1=RA, a2=RB, branch=01, no writes.
  - JAL 1000: a3=RA, d3=11, branch=10.
  - JLR 1001: a1=RB, a3=RA, d3=11, branch=11.
- LM 0110 / SM 0111, state machine:
  - IDLE: on accept, emit a micro-op for the lowest set mask bit i, with uop_offset=0.
  - If further bits remain: go to MULTI, latch the remaining mask, set fetch_stall=1.
  - MULTI: each unstalled cycle emit the next lowest set bit, increment uop_offset, clear that bit. When the last bit is emitted: last_uop=1, fetch_stall=0, return to IDLE.
  - LM micro-op: a1=RA, a3=i, src2=11, d3=01, rr_wr_en=1.
  - SM micro-op: a1=RA, a2=i, src2=11, mem_wr_en=1.
  - Mask 0: the instruction is consumed in one cycle with out_valid=0 and no writes.
  - Single set bit: one micro-op, fetch_stall never asserts.
  - Mask all ones: NUM_REGS micro-ops; uop_offset wraps never, since it ends at NUM_REGS-1.
- Undefined opcodes (1010, 1011, 1101–1111): see the optional feature.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: undefined opcodes give out_valid=1 and an extra output illegal_op=1, with all writes and branch_type forced to 0.
- Undefined: no illegal_op port; undefined opcodes decode as ADD, matching the legacy default.

Decomposition:
- Shared package ctrl_pkg: opcode localparams, and encodings for src2, alu_oper, d3_sel and branch_type.
- One sub-module ctrl_field_decode: combinational opcode-to-fields table. The top level holds the LM/SM sequencer, the priority encoder and the output registers.

Test Plan:
- ADD R3=R1+R2 (0x1298) -> next cycle out_valid=1, a1=1, a2=2, a3=3, rr_wr_en=1, last_uop=1, fetch_stall=0.
- LM RA=2, mask 0x15 -> three micro-ops in consecutive cycles with a3=0,2,4 and uop_offset=0,1,2. fetch_stall is high for the first two only; last_uop is set on the third.
- SM mask 0x80 with stall_in high for 2 cycles mid-stream -> outputs held, then a single micro-op with a2=7, mem_wr_en=1.
- LM mask 0xFF, flush asserted after the 3rd micro-op -> next cycle out_valid=0, fetch_stall=0, state IDLE.
- reset pulsed during MULTI -> all outputs 0 immediately. LM with mask 0x00 -> out_valid stays 0 and there are no writes.
- Opcode 1111 -> illegal_op=1 when ILLEGAL_TRAP_EN is defined; otherwise decoded as ADD.
